// File: rtl/vga_textbuf_arbiter.sv
// Shares one single-port sync text RAM between video reads (absolute priority) and a
// queued host writer. Define VGA_TEXTBUF_VBLANK_ONLY_EN to retire host writes only during vblank.
module vga_textbuf_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic              px_clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              vblank,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [FIFO_AW:0]  fifo_level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    // Host handshake: a write transfers on the rising edge where wr_valid && wr_ready;
    // wr_ready depends only on the registered level, so a full FIFO never accepts.

    logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
    logic [DATA_W-1:0]  data_mem_q [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic [1:0]         vid_pipe_q, vid_pipe_d;

    logic push;
    logic pop;
    logic drain_ok;

`ifdef VGA_TEXTBUF_VBLANK_ONLY_EN
    assign drain_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign drain_ok      = 1'b1;
`endif

    assign wr_ready = !reset && (count_q != FULL_LEVEL);
    assign push     = wr_valid && wr_ready;
    // Video owns the port whenever it asks; writes only fill otherwise idle slots.
    assign pop      = !vid_req && (count_q != '0) && drain_ok;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vid_pipe_d  = {vid_pipe_q[0], vid_req};

        if (vid_req) begin
            ram_addr_d = vid_addr;
        end else if (pop) begin
            ram_addr_d  = addr_mem_q[rd_ptr_q];
            ram_wdata_d = data_mem_q[rd_ptr_q];
            ram_we_d    = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_pipe_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_pipe_q  <= vid_pipe_d;
        end
    end

    // Storage needs no reset: entries are only read once the level says they are valid.
    always_ff @(posedge px_clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wr_addr;
            data_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign fifo_level = count_q;
    assign vid_rdata  = ram_rdata;
    assign vid_rvalid = vid_pipe_q[1];

endmodule

// File: tb/tb_vga_textbuf_arbiter.sv
// Directed bench for vga_textbuf_arbiter: per-cycle vector table plus hand-written
// sequences for read data, the write/read hazard, vblank gating and mid-burst reset.
module tb_vga_textbuf_arbiter;

    logic       px_clk = 1'b0;
    logic       reset;
    logic       vid_req;
    logic [7:0] vid_addr;
    logic [7:0] vid_rdata;
    logic       vid_rvalid;
    logic       vblank;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 px_clk = ~px_clk;

    vga_textbuf_arbiter #(.ADDR_W(8), .DATA_W(8), .FIFO_AW(2)) dut (
        .px_clk(px_clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .vblank(vblank),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level)
    );

    // Single-port synchronous RAM model; 0x22 is seeded with a known character.
    logic [7:0] ram_mem [256];
    always @(posedge px_clk) begin
        if (reset) begin
            ram_mem[8'h22] <= 8'h7A;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    typedef struct {
        logic       vr;
        logic [7:0] va;
        logic       wv;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [2:0] exp_level;
        logic       exp_rdy;
        logic       exp_rv;
    } vec_t;

    localparam int NVEC = 35;
    vec_t vecs [NVEC];

    function automatic vec_t v(input logic vr, input logic [7:0] va, input logic wv,
                               input logic [7:0] wa, input logic [7:0] wd,
                               input logic we, input logic [7:0] ea, input logic [7:0] ed,
                               input logic [2:0] lvl, input logic rdy, input logic rv);
        vec_t r;
        r.vr = vr; r.va = va; r.wv = wv; r.wa = wa; r.wd = wd;
        r.exp_we = we; r.exp_addr = ea; r.exp_wdata = ed;
        r.exp_level = lvl; r.exp_rdy = rdy; r.exp_rv = rv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vr, input logic [7:0] va, input logic vb,
                         input logic wv, input logic [7:0] wa, input logic [7:0] wd);
        vid_req  = vr;
        vid_addr = va;
        vblank   = vb;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk_ram(input string tag, input logic we, input logic [7:0] a,
                           input logic [7:0] d, input logic [2:0] lvl);
        chk({tag, "_we"}, ram_we, we);
        if (we) begin
            chk({tag, "_addr"}, ram_addr, a);
            chk({tag, "_wdata"}, ram_wdata, d);
        end
        chk({tag, "_level"}, fifo_level, lvl);
    endtask

    initial begin
        // Single-write latency, then four queued behind video, pointer wrap with
        // simultaneous push/pop, and drains interleaved with alternating video reads.
        vecs[0]  = v(0, 8'h00, 1, 8'h10, 8'h41, 0, 8'h00, 8'h00, 1, 1, 0);
        vecs[1]  = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h10, 8'h41, 0, 1, 0);
        vecs[2]  = v(0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h10, 8'h41, 0, 1, 0);
        vecs[3]  = v(1, 8'h30, 1, 8'h01, 8'hA1, 0, 8'h30, 8'h41, 1, 1, 0);
        vecs[4]  = v(1, 8'h31, 1, 8'h02, 8'hA2, 0, 8'h31, 8'h41, 2, 1, 1);
        vecs[5]  = v(1, 8'h32, 1, 8'h03, 8'hA3, 0, 8'h32, 8'h41, 3, 1, 1);
        vecs[6]  = v(1, 8'h33, 1, 8'h04, 8'hA4, 0, 8'h33, 8'h41, 4, 0, 1);
        vecs[7]  = v(1, 8'h34, 1, 8'h05, 8'hA5, 0, 8'h34, 8'h41, 4, 0, 1);
        vecs[8]  = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h01, 8'hA1, 3, 1, 1);
        vecs[9]  = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h02, 8'hA2, 2, 1, 0);
        vecs[10] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h03, 8'hA3, 1, 1, 0);
        vecs[11] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h04, 8'hA4, 0, 1, 0);
        vecs[12] = v(0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h04, 8'hA4, 0, 1, 0);
        vecs[13] = v(1, 8'h40, 1, 8'h11, 8'hB1, 0, 8'h40, 8'hA4, 1, 1, 0);
        vecs[14] = v(1, 8'h41, 1, 8'h12, 8'hB2, 0, 8'h41, 8'hA4, 2, 1, 1);
        vecs[15] = v(0, 8'h00, 1, 8'h13, 8'hB3, 1, 8'h11, 8'hB1, 2, 1, 1);
        vecs[16] = v(0, 8'h00, 1, 8'h14, 8'hB4, 1, 8'h12, 8'hB2, 2, 1, 0);
        vecs[17] = v(0, 8'h00, 1, 8'h15, 8'hB5, 1, 8'h13, 8'hB3, 2, 1, 0);
        vecs[18] = v(0, 8'h00, 1, 8'h16, 8'hB6, 1, 8'h14, 8'hB4, 2, 1, 0);
        vecs[19] = v(0, 8'h00, 1, 8'h17, 8'hB7, 1, 8'h15, 8'hB5, 2, 1, 0);
        vecs[20] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h16, 8'hB6, 1, 1, 0);
        vecs[21] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h17, 8'hB7, 0, 1, 0);
        vecs[22] = v(0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h17, 8'hB7, 0, 1, 0);
        vecs[23] = v(1, 8'h50, 1, 8'h61, 8'hC1, 0, 8'h50, 8'hB7, 1, 1, 0);
        vecs[24] = v(1, 8'h51, 1, 8'h62, 8'hC2, 0, 8'h51, 8'hB7, 2, 1, 1);
        vecs[25] = v(1, 8'h52, 1, 8'h63, 8'hC3, 0, 8'h52, 8'hB7, 3, 1, 1);
        vecs[26] = v(1, 8'h53, 1, 8'h64, 8'hC4, 0, 8'h53, 8'hB7, 4, 0, 1);
        vecs[27] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h61, 8'hC1, 3, 1, 1);
        vecs[28] = v(1, 8'h54, 0, 8'h00, 8'h00, 0, 8'h54, 8'hC1, 3, 1, 0);
        vecs[29] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h62, 8'hC2, 2, 1, 1);
        vecs[30] = v(1, 8'h55, 0, 8'h00, 8'h00, 0, 8'h55, 8'hC2, 2, 1, 0);
        vecs[31] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h63, 8'hC3, 1, 1, 1);
        vecs[32] = v(1, 8'h56, 0, 8'h00, 8'h00, 0, 8'h56, 8'hC3, 1, 1, 0);
        vecs[33] = v(0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h64, 8'hC4, 0, 1, 1);
        vecs[34] = v(0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h64, 8'hC4, 0, 1, 0);

        // Reset held 3 cycles with a write offered.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 1, 8'hEE, 8'hEE);
            chk($sformatf("rst%0d_wr_ready", i), wr_ready, 0);
            chk($sformatf("rst%0d_we", i), ram_we, 0);
            chk($sformatf("rst%0d_addr", i), ram_addr, 0);
            chk($sformatf("rst%0d_wdata", i), ram_wdata, 0);
            chk($sformatf("rst%0d_level", i), fifo_level, 0);
            chk($sformatf("rst%0d_rvalid", i), vid_rvalid, 0);
        end
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].vr, vecs[i].va, 1, vecs[i].wv, vecs[i].wa, vecs[i].wd);
            chk($sformatf("v%0d_we", i), ram_we, vecs[i].exp_we);
            chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_level", i), fifo_level, vecs[i].exp_level);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].exp_rdy);
            chk($sformatf("v%0d_rvalid", i), vid_rvalid, vecs[i].exp_rv);
        end

        // Read of 0x22 while a write to 0x22 sits queued: old value, then new value.
        drive(1, 8'h22, 1, 1, 8'h22, 8'h99);
        chk("haz_a_level", fifo_level, 1);
        drive(1, 8'h22, 1, 0, 8'h00, 8'h00);
        chk("haz_b_rvalid", vid_rvalid, 1);
        chk("haz_b_rdata", vid_rdata, 8'h7A);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk_ram("haz_c", 1, 8'h22, 8'h99, 0);
        chk("haz_c_rvalid", vid_rvalid, 1);
        chk("haz_c_rdata", vid_rdata, 8'h7A);
        drive(1, 8'h22, 1, 0, 8'h00, 8'h00);
        chk("haz_d_we", ram_we, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk("haz_e_rvalid", vid_rvalid, 1);
        chk("haz_e_rdata", vid_rdata, 8'h99);

        // Two writes queued while vblank is low, then vblank rises.
        drive(0, 8'h00, 0, 1, 8'h70, 8'hD0);
        chk_ram("vb1", 0, 8'h00, 8'h00, 1);
        drive(0, 8'h00, 0, 1, 8'h71, 8'hD1);
`ifdef VGA_TEXTBUF_VBLANK_ONLY_EN
        chk_ram("vb2", 0, 8'h00, 8'h00, 2);
        drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
        chk_ram("vb3", 0, 8'h00, 8'h00, 2);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk_ram("vb4", 1, 8'h70, 8'hD0, 1);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk_ram("vb5", 1, 8'h71, 8'hD1, 0);
`else
        chk_ram("vb2", 1, 8'h70, 8'hD0, 1);
        drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
        chk_ram("vb3", 1, 8'h71, 8'hD1, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk_ram("vb4", 0, 8'h00, 8'h00, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk_ram("vb5", 0, 8'h00, 8'h00, 0);
`endif

        // Reset with three writes queued behind video discards them.
        drive(1, 8'h90, 1, 1, 8'h80, 8'hE0);
        drive(1, 8'h91, 1, 1, 8'h81, 8'hE1);
        drive(1, 8'h92, 1, 1, 8'h82, 8'hE2);
        chk("rq_level", fifo_level, 3);
        reset = 1'b1;
        vid_req = 1'b0;
        #1;
        chk("rq_wr_ready_in_reset", wr_ready, 0);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk("rq_level_reset", fifo_level, 0);
        chk("rq_addr_reset", ram_addr, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 0, 8'h00, 8'h00);
            chk($sformatf("rq_post%0d_we", i), ram_we, 0);
            chk($sformatf("rq_post%0d_level", i), fifo_level, 0);
            chk($sformatf("rq_post%0d_wr_ready", i), wr_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
